// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache, one 32-bit word per frame.
//
// Fetch side : imemREN/imemaddr in, ihit/imemload out. Hits answer in the same
//              cycle. The lookup is purely combinational.
// Memory side: iREN/iaddr out, iwait/iload in. Each miss runs a single-word fill.
//              iload is taken on the first cycle of FETCH with iwait low.
// Clock/reset: CLK, RST (synchronous, active-high).
// Optional   : define ICACHE_STATS_EN to add hit_count/miss_count outputs.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | lookups enabled; a requested miss latches miss_addr
// FETCH | iREN high, waiting for iwait low to write the frame

module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FETCH} state_e;

  state_e            state_q, state_d;
  logic [29:0]       miss_addr_q, miss_addr_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic [TW-1:0]     tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  logic [IW-1:0]     req_idx;
  logic [TW-1:0]     req_tag;
  logic [IW-1:0]     fill_idx;
  logic [TW-1:0]     fill_tag;
  logic              lookup_hit;
  logic              fill_we;
  logic              unused_byte_bits;

  assign req_idx          = imemaddr[IW+1:2];
  assign req_tag          = imemaddr[31:IW+2];
  assign fill_idx         = miss_addr_q[IW-1:0];
  assign fill_tag         = miss_addr_q[29:IW];
  assign unused_byte_bits = ^imemaddr[1:0];

  always_comb begin
    lookup_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    ihit        = (state_q == IDLE) && imemREN && lookup_hit;
    imemload    = ihit ? data_q[req_idx] : 32'h0;
    iREN        = (state_q == FETCH);
    iaddr       = iREN ? {miss_addr_q, 2'b00} : 32'h0;
    fill_we     = (state_q == FETCH) && !iwait;

    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    valid_d     = valid_q;
    case (state_q)
      IDLE: begin
        if (imemREN && !lookup_hit) begin
          miss_addr_d = {req_tag, req_idx};
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // A redirect of imemaddr is ignored here; the fill always finishes
        // for miss_addr and the new address is looked up back in IDLE.
        if (!iwait) begin
          valid_d[fill_idx] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q + {31'd0, ihit};
    miss_count_d = miss_count_q + {31'd0, (state_q == IDLE) && (state_d == FETCH)};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  // Tag/data arrays have no reset. They are written only outside reset, so a
  // reset on the same edge as a completing fill leaves the frame untouched.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      valid_q     <= valid_d;
      if (fill_we) begin
        tag_q[fill_idx]  <= fill_tag;
        data_q[fill_idx] <= iload;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;

  icache #(.SETS(16)) dut (
    .CLK(CLK),
    .RST(RST),
    .imemREN(imemREN),
    .imemaddr(imemaddr),
    .ihit(ihit),
    .imemload(imemload),
    .iREN(iREN),
    .iaddr(iaddr),
    .iwait(iwait),
    .iload(iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    RST      = 1'b1;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;

    // reset
    tick();
    chk("rst_ihit", {31'd0, ihit}, 32'd0);
    chk("rst_imemload", imemload, 32'h0);
    chk("rst_iREN", {31'd0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    RST = 1'b0;

    // cold miss on 0x40, three wait cycles
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0040;
    #1;
    chk("cold_miss_ihit", {31'd0, ihit}, 32'd0);
    tick();
    chk("cold_iREN_rise", {31'd0, iREN}, 32'd1);
    chk("cold_iaddr", iaddr, 32'h40);
    chk("cold_fetch_ihit", {31'd0, ihit}, 32'd0);
    tick();
    chk("cold_wait_iaddr", iaddr, 32'h40);
    tick();
    tick();
    iwait = 1'b0;
    iload = 32'h2008_0005;
    #1;
    chk("cold_accept_iREN", {31'd0, iREN}, 32'd1);
    tick();
    iwait = 1'b1;
    iload = 32'h0;
    #1;
    chk("cold_post_ihit", {31'd0, ihit}, 32'd1);
    chk("cold_post_load", imemload, 32'h2008_0005);
    chk("cold_post_iREN", {31'd0, iREN}, 32'd0);
    chk("cold_post_iaddr", iaddr, 32'h0);

    // hit path: three more hit cycles
    tick();
    chk("hit_ihit", {31'd0, ihit}, 32'd1);
    chk("hit_iREN", {31'd0, iREN}, 32'd0);
    tick();
    tick();
`ifdef ICACHE_STATS_EN
    chk("stats_miss_count", miss_count, 32'd1);
    chk("stats_hit_count", hit_count, 32'd3);
    tick();
    imemREN = 1'b0;
    #1;
    chk("stats_hit_count4", hit_count, 32'd4);
`else
    tick();
    imemREN = 1'b0;
`endif

    // dropped request on a frame that would hit
    #1;
    chk("drop_ihit", {31'd0, ihit}, 32'd0);
    chk("drop_load", imemload, 32'h0);
    tick();
    chk("drop_no_fetch", {31'd0, iREN}, 32'd0);
    imemREN = 1'b1;

    // conflict: 0x80 evicts 0x40 (index 0), zero wait states
    imemaddr = 32'h0000_0080;
    #1;
    chk("conf80_miss", {31'd0, ihit}, 32'd0);
    tick();
    chk("conf80_iaddr", iaddr, 32'h80);
    iwait = 1'b0;
    iload = 32'hAAAA_0080;
    tick();
    iwait = 1'b1;
    #1;
    chk("conf80_hit", {31'd0, ihit}, 32'd1);
    chk("conf80_load", imemload, 32'hAAAA_0080);
    imemaddr = 32'h0000_0040;
    #1;
    chk("conf40_miss", {31'd0, ihit}, 32'd0);
    tick();
    chk("conf40_iaddr", iaddr, 32'h40);
    iwait = 1'b0;
    iload = 32'h2008_0005;
    tick();
    iwait = 1'b1;
    #1;
    chk("conf40_refill", imemload, 32'h2008_0005);

    // redirect mid-fill
    imemaddr = 32'h0000_0100;
    #1;
    chk("redir_miss", {31'd0, ihit}, 32'd0);
    tick();
    chk("redir_iaddr", iaddr, 32'h100);
    imemaddr = 32'h0000_0200;
    #1;
    chk("redir_hold_iaddr", iaddr, 32'h100);
    chk("redir_fetch_ihit", {31'd0, ihit}, 32'd0);
    tick();
    chk("redir_hold_iaddr2", iaddr, 32'h100);
    iwait = 1'b0;
    iload = 32'h1111_0100;
    tick();
    iwait = 1'b1;
    #1;
    chk("redir_new_miss", {31'd0, ihit}, 32'd0);
    chk("redir_idle_iREN", {31'd0, iREN}, 32'd0);
    tick();
    chk("redir_new_iaddr", iaddr, 32'h200);
    iwait = 1'b0;
    iload = 32'h2222_0200;
    tick();
    iwait = 1'b1;
    #1;
    chk("redir_new_load", imemload, 32'h2222_0200);

    // reset during FETCH, with the fill completing on the reset edge
    imemaddr = 32'h0000_0300;
    #1;
    chk("rfetch_miss", {31'd0, ihit}, 32'd0);
    tick();
    chk("rfetch_iREN", {31'd0, iREN}, 32'd1);
    RST   = 1'b1;
    iwait = 1'b0;
    iload = 32'hDEAD_BEEF;
    tick();
    RST   = 1'b0;
    iwait = 1'b1;
    #1;
    chk("rfetch_iREN_low", {31'd0, iREN}, 32'd0);
    chk("rfetch_iaddr_zero", iaddr, 32'h0);
    chk("rfetch_not_written", {31'd0, ihit}, 32'd0);
    tick();
    chk("rfetch_remiss_iREN", {31'd0, iREN}, 32'd1);
    chk("rfetch_remiss_iaddr", iaddr, 32'h300);
    iwait = 1'b0;
    iload = 32'h3333_0300;
    tick();
    iwait = 1'b1;
    #1;
    chk("rfetch_fill_load", imemload, 32'h3333_0300);

    // different index does not disturb frame 0
    imemaddr = 32'h0000_0044;
    #1;
    chk("idx1_miss", {31'd0, ihit}, 32'd0);
    tick();
    chk("idx1_iaddr", iaddr, 32'h44);
    iwait = 1'b0;
    iload = 32'h4444_0044;
    tick();
    iwait = 1'b1;
    #1;
    chk("idx1_load", imemload, 32'h4444_0044);
    imemaddr = 32'h0000_0302;
    #1;
    chk("idx0_still_hit", {31'd0, ihit}, 32'd1);
    chk("idx0_still_load", imemload, 32'h3333_0300);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipeline's fetch stage and the memory controller. It answers fetch requests (`imemREN`/`imemaddr`) with `ihit`/`imemload`: hits return the same cycle, misses run a single-word fill over the memory-side `iREN`/`iwait` handshake. It holds one 32-bit word per frame and never writes back.

## Interface
- `SETS`, default 16: number of frames, power of two, minimum 2. Index width `IW = log2(SETS)`.
- `CLK`  in  1: clock; all state updates on the rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `imemREN`  in  1: fetch request from the datapath.
- `imemaddr`  in  32: byte address of the fetch; bits [1:0] ignored.
- `ihit`  out  1: `imemload` is valid this cycle.
- `imemload`  out  32: instruction word.
- `iREN`  out  1: read request to the memory controller.
- `iaddr`  out  32: word-aligned fill address.
- `iwait`  in  1: memory busy. When low while `iREN` is high, `iload` is valid.
- `iload`  in  32: fill data.

## Operation
- **Address split:** index = `imemaddr[IW+1:2]`; tag = `imemaddr[31:IW+2]`.
- **Frame storage:** each frame holds `valid`, `tag` and `data`.
- **FSM states:** IDLE, FETCH.
- **IDLE:**
  - `ihit = imemREN & valid[idx] & (tag[idx] == tag)`.
  - `imemload = data[idx]` when `ihit` is high, else 0.
  - If `imemREN` is high and the access misses, latch `{tag, idx}` into `miss_addr` and go to FETCH.
  - `iREN` = 0.
- **FETCH:**
  - `iREN` = 1; `iaddr = {miss_addr, 2'b00}`.
  - `ihit` = 0 regardless of `imemaddr`.
  - On an edge where `iwait` = 0: write `data <= iload`, `tag <= miss_addr` tag, `valid <= 1` at the `miss_addr` index, then go to IDLE.
- **Redirect during FETCH:** if `imemaddr` changes while in FETCH (branch or jump redirect), the fill still completes for `miss_addr`. The new address is looked up in IDLE afterwards and may miss again.
- **Idle outputs:** when not in FETCH, `iaddr` = 0.
- **Reset:**
  - All `valid` bits clear, state goes to IDLE, `miss_addr` clears.
  - Tag and data storage need not be cleared.
  - Reset asserted during FETCH abandons the fill: no frame is written and `iREN` is low in the cycle after the reset edge.
- **Request dropped:** `imemREN` low means no lookup, no miss and `ihit` = 0. This applies even if the frame would hit.
- **Aliasing:** two addresses with equal index and different tag evict each other. The last fill wins.

## Timing
- **Reset values:** `ihit` = 0, `imemload` = 0, `iREN` = 0, `iaddr` = 0.
- **Hit latency:** 0 cycles; combinational from `imemaddr` and `imemREN`.
- **Miss latency:**
  - Miss seen in cycle N.
  - `iREN` high from cycle N+1.
  - Memory returns in cycle M (first cycle with `iwait` = 0 in FETCH).
  - State is IDLE in cycle M+1 and `ihit` = 1 then, if `imemaddr` is unchanged.
  - With zero memory wait states this is a 2-cycle miss penalty.
- **Memory handshake:** `iREN` and `iaddr` stay stable while `iwait` = 1. `iREN` drops in the cycle after the accepted word.
- **Simultaneous events:** `RST` has priority over a fill completing on the same edge.

## Configuration
- `ICACHE_STATS_EN`: when defined, adds two outputs:
  - `hit_count` (32, out): increments on each edge where `ihit` = 1.
  - `miss_count` (32, out): increments on each IDLE→FETCH transition.
  - Both wrap modulo 2^32 and reset to 0 on `RST`.
- When `ICACHE_STATS_EN` is undefined, the ports and counters are absent and all other behaviour is identical.

## Test plan
- **Reset, then cold miss:** `RST` 1 cycle; `imemREN` = 1, `imemaddr` = 0x0000_0040, memory returns 0x2008_0005 after 3 wait cycles.
  - `iREN` rises 1 cycle after the miss with `iaddr` = 0x40.
  - `ihit` = 1 with `imemload` = 0x2008_0005 one cycle after `iwait` falls.
- **Hit path:** re-read 0x40 → `ihit` = 1 in the same cycle; `iREN` stays 0.
- **Conflict eviction (SETS = 16):** read 0x40, then 0x80 (same index 0, different tag).
  - 0x80 misses and fills.
  - Re-reading 0x40 misses again with `iaddr` = 0x40.
- **Redirect mid-fill:** miss on 0x100, then `imemaddr` changes to 0x200 while `iwait` = 1.
  - `iaddr` holds 0x100 until the word arrives.
  - Next cycle, 0x200 misses and `iaddr` = 0x200.
- **Reset during FETCH:** assert `RST` while `iREN` = 1 and `iwait` = 1.
  - Next cycle `iREN` = 0.
  - A subsequent read of the same address misses, showing the frame was not written.
- **Stats (`ICACHE_STATS_EN` defined):** 1 cold miss, then 3 hit cycles on 0x40 → `miss_count` = 1, `hit_count` = 4 (3 hit cycles plus the post-fill hit).
